sq_odd_squarer: RTL

SQ_ODD_SQUARER -- requirements
Module: sq_odd_squarer

---
 rtl/sq_odd_squarer.sv | 109 ++++++++++
 1 files changed

// File: rtl/sq_odd_squarer.sv
// Squares an unsigned root by accumulating successive odd numbers (1+3+5+...), one step per enabled cycle.
// Optional macro SQ_FASTPATH_EN: root=1 completes in a single cycle instead of running one RUN step.
module sq_odd_squarer #(
    parameter int  ROOT_W = 6,
    localparam int SQ_W   = 2 * ROOT_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [ROOT_W-1:0] in_root,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SQ_W-1:0]   out_square,
    output logic [ROOT_W-1:0] out_root,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // enable low freezes everything, so no transfer can complete while it is low.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [SQ_W-1:0]     square, square_next;
    logic [SQ_W-1:0]     odd, odd_next;
    logic [ROOT_W-1:0]   count, count_next;
    logic [ROOT_W-1:0]   root, root_next;
    logic                accept;

    assign in_ready   = (state == IDLE) && enable;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == DONE);
    assign out_square = square;
    assign out_root   = root;
    assign dbg_state  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            square <= '0;
            odd    <= SQ_W'(3);
            count  <= '0;
            root   <= '0;
        end else begin
            state  <= state_next;
            square <= square_next;
            odd    <= odd_next;
            count  <= count_next;
            root   <= root_next;
        end
    end

    always_comb begin
        state_next  = state;
        square_next = square;
        odd_next    = odd;
        count_next  = count;
        root_next   = root;
        case (state)
            IDLE: begin
                if (accept) begin
                    root_next = in_root;
                    if (in_root == '0) begin
                        square_next = '0;
                        state_next  = DONE;
                    end
`ifdef SQ_FASTPATH_EN
                    else if (in_root == ROOT_W'(1)) begin
                        square_next = SQ_W'(1);
                        state_next  = DONE;
                    end
`endif
                    else begin
                        square_next = SQ_W'(1);
                        odd_next    = SQ_W'(3);
                        count_next  = ROOT_W'(1);
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                if (enable) begin
                    if (count == root) begin
                        state_next = DONE;
                    end else begin
                        // count never exceeds root, so neither square nor odd can wrap
                        square_next = square + odd;
                        odd_next    = odd + SQ_W'(2);
                        count_next  = count + ROOT_W'(1);
                    end
                end
            end
            DONE: begin
                if (enable && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
